// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler
//   Sequencer and round-robin arbiter for a 32-bit Fibonacci LFSR
//   (x^32+x^30+x^17+x^12+x^3+x+1). It advances the state STEPS_PER_WORD
//   shifts per word and then offers the word to NREQ requesters. Exactly one
//   requester takes each word.
// Ports
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   enable     run request; 0 pauses generation
//   seed_load  one-cycle pulse: load seed_val (or SEED if seed_val==0)
//   seed_val   seed value
//   req        per-requester level request, held until granted
//   gnt        one-hot grant; the word transfers on the edge where gnt[i]=1
//   rnd_valid  a finished word is on rnd_data
//   rnd_data   issued random word
//   busy       state != IDLE
//   lock_err   sticky: zero seed or zero state was detected
module lfsr_rr_scheduler #(
  parameter int          NREQ           = 4,
  parameter int          STEPS_PER_WORD = 32,
  parameter logic [31:0] SEED           = 32'hACE12468
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            enable,
  input  logic            seed_load,
  input  logic [31:0]     seed_val,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [31:0]     rnd_data,
  output logic            busy,
  output logic            lock_err
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] OFFER = 2'd2;

  localparam logic [7:0]    LAST    = 8'(STEPS_PER_WORD - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [1:0]      st;
  logic [31:0]     s;
  logic [31:0]     s_nxt;
  logic [7:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic [NREQ-1:0] arb;
  logic            found;

  assign s_nxt = {s[30:0], s[31] ^ s[29] ^ s[16] ^ s[11] ^ s[2] ^ s[0]};

  // Search starts one past the last winner, so the last winner has the lowest
  // priority next time.
  always_comb begin
    arb   = '0;
    pick  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        arb[idx] = 1'b1;
        pick     = idx;
      end
    end
  end

  // A seed load in OFFER discards the word, so the grant is suppressed that
  // cycle.
  assign gnt       = (st == OFFER && !seed_load) ? arb : '0;
  assign rnd_valid = (st == OFFER);
  assign busy      = (st != IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st       <= IDLE;
      s        <= SEED;
      cnt      <= '0;
      ptr      <= PTR_RST;
      rnd_data <= '0;
      lock_err <= 1'b0;
    end else if (seed_load) begin
      // A zero seed would lock the LFSR, so it is replaced and flagged.
      s        <= (seed_val == 32'd0) ? SEED : seed_val;
      lock_err <= (seed_val == 32'd0);
      cnt      <= '0;
      st       <= enable ? FILL : IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (enable) begin
            st  <= FILL;
            cnt <= '0;
          end
        end
        FILL: begin
          if (s == 32'd0) begin
            // A lock-up state recovers to SEED without spending a step.
            s        <= SEED;
            lock_err <= 1'b1;
          end else if (enable) begin
            s <= s_nxt;
            if (cnt == LAST) begin
              rnd_data <= s_nxt;
              cnt      <= '0;
              st       <= OFFER;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        OFFER: begin
          if (found) begin
            ptr <= pick;
            st  <= enable ? FILL : IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Testbench for lfsr_rr_scheduler. Two instances share clk and clr_n:
//   u_a: STEPS_PER_WORD=1. A scoreboard checks the data and grant of every
//        word against the reference model.
//   u_b: default parameters. Directed checks cover latency, hold, seed
//        handling and reset.
module tb_lfsr_rr_scheduler;
  localparam int          NREQ = 4;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_en = 1'b0, a_sl = 1'b0;
  logic [31:0]     a_sv = '0;
  logic [NREQ-1:0] a_req = '0;
  logic [NREQ-1:0] a_gnt;
  logic            a_vld, a_busy, a_lerr;
  logic [31:0]     a_data;

  logic            b_en = 1'b0, b_sl = 1'b0;
  logic [31:0]     b_sv = '0;
  logic [NREQ-1:0] b_req = '0;
  logic [NREQ-1:0] b_gnt;
  logic            b_vld, b_busy, b_lerr;
  logic [31:0]     b_data;

  lfsr_rr_scheduler #(.NREQ(NREQ), .STEPS_PER_WORD(1), .SEED(SEED)) u_a (
    .clk(clk), .clr_n(clr_n), .enable(a_en), .seed_load(a_sl), .seed_val(a_sv),
    .req(a_req), .gnt(a_gnt), .rnd_valid(a_vld), .rnd_data(a_data),
    .busy(a_busy), .lock_err(a_lerr));

  lfsr_rr_scheduler #(.NREQ(NREQ), .STEPS_PER_WORD(32), .SEED(SEED)) u_b (
    .clk(clk), .clr_n(clr_n), .enable(b_en), .seed_load(b_sl), .seed_val(b_sv),
    .req(b_req), .gnt(b_gnt), .rnd_valid(b_vld), .rnd_data(b_data),
    .busy(b_busy), .lock_err(b_lerr));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the polynomial applied n times, and the round-robin rule.
  function automatic logic [31:0] adv(input logic [31:0] s0, input int n);
    logic [31:0] s = s0;
    for (int k = 0; k < n; k++)
      s = {s[30:0], s[31] ^ s[29] ^ s[16] ^ s[11] ^ s[2] ^ s[0]};
    return s;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return last;
  endfunction

  typedef struct {
    logic [31:0]     data;
    logic [NREQ-1:0] gnt;
  } exp_t;
  exp_t sbq[$];
  int   xfers = 0;

  // Monitor for u_a: a transfer is any cycle with rnd_valid and a grant.
  always @(negedge clk) begin
    if (clr_n) begin
      if (a_vld && |a_gnt) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got word %0h gnt %0b, expected none", a_data, a_gnt);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_data", a_data, e.data);
          check("sb_gnt", a_gnt, e.gnt);
        end
        xfers++;
      end else if (!a_vld) begin
        check("a_gnt_idle", a_gnt, '0);
      end
    end
  end

  logic [31:0] m_s;
  int          m_ptr;

  // Issue one word on u_a with request vector r. All calls start 1 time unit
  // after a rising edge.
  task automatic a_word(input logic [NREQ-1:0] r);
    exp_t e;
    int   tgt, c, w;
    logic [NREQ-1:0] g;
    if ($urandom_range(0, 3) == 0) begin
      a_en = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 a_en = 1'b1;
    end
    m_s   = adv(m_s, 1);
    w     = rr_pick(r, m_ptr);
    m_ptr = w;
    g     = '0;
    g[w]  = 1'b1;
    e.data = m_s;
    e.gnt  = g;
    sbq.push_back(e);
    tgt   = xfers + 1;
    a_req = r;
    c     = 0;
    while (xfers < tgt && c < 200) begin
      @(posedge clk);
      c++;
    end
    if (xfers < tgt) begin
      n_chk++;
      n_fail++;
      $display("FAIL a_word_timeout: got %0d transfers, expected %0d", xfers, tgt);
    end
    #1 a_req = '0;
  endtask

  // Count edges until u_b presents a word.
  task automatic b_wait(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!b_vld && n < 100);
  endtask

  task automatic b_first_word(input string tag);
    int n;
    b_en = 1'b1;
    b_wait(n);
    check({tag, "_latency"}, n, 33);
    check({tag, "_data"}, b_data, adv(SEED, 32));
  endtask

  task automatic reset_pulse(input string tag);
    #3 clr_n = 1'b0;
    b_en = 1'b0;
    b_req = '0;
    #1;
    check({tag, "_vld"},  b_vld,  1'b0);
    check({tag, "_data"}, b_data, 32'd0);
    check({tag, "_busy"}, b_busy, 1'b0);
    check({tag, "_gnt"},  b_gnt,  '0);
    check({tag, "_lerr"}, b_lerr, 1'b0);
    @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] w1, w2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_vld",  a_vld,  1'b0);
    check("rst_a_data", a_data, 32'd0);
    check("rst_a_gnt",  a_gnt,  '0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_b_vld",  b_vld,  1'b0);
    check("rst_b_lerr", b_lerr, 1'b0);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // u_a: seed 1, one step per word, then fixed and random request patterns.
    a_sl = 1'b1; a_sv = 32'h1; a_en = 1'b1;
    @(posedge clk);
    #1 a_sl = 1'b0;
    m_s = 32'h1;
    m_ptr = NREQ - 1;
    repeat (3) a_word(4'b0001);
    repeat (5) a_word(4'b1111);
    repeat (3) a_word(4'b0100);
    repeat (20) a_word(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    a_en = 1'b0;
    @(posedge clk);
    #1;
    check("sb_drained", sbq.size(), 0);

    // u_b: latency from reset.
    w1 = adv(SEED, 32);
    w2 = adv(w1, 32);
    b_first_word("pwr");

    // Hold in OFFER with no request.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("hold_vld",  b_vld,  1'b1);
      check("hold_data", b_data, w1);
      check("hold_gnt",  b_gnt,  '0);
    end
    b_req = 4'b0001;
    #1 check("b_gnt0", b_gnt, 4'b0001);
    @(posedge clk);
    #1 b_req = '0;
    check("post_gnt_vld",  b_vld,  1'b0);
    check("post_gnt_busy", b_busy, 1'b1);

    // Pause for 5 cycles after 10 steps: 22 more edges are needed.
    repeat (10) @(posedge clk);
    #1 b_en = 1'b0;
    repeat (5) @(posedge clk);
    check("pause_vld", b_vld, 1'b0);
    check("pause_busy", b_busy, 1'b1);
    #1 b_en = 1'b1;
    b_wait(n);
    check("pause_latency", n, 22);
    check("pause_data", b_data, w2);

    // seed_load in OFFER with a pending request: no grant, word dropped.
    b_req = 4'b0010; b_sl = 1'b1; b_sv = 32'h5;
    #1 check("sl_gnt", b_gnt, '0);
    @(posedge clk);
    #1 b_sl = 1'b0;
    b_req = '0;
    check("sl_vld",  b_vld,  1'b0);
    check("sl_gnt2", b_gnt,  '0);
    check("sl_busy", b_busy, 1'b1);

    // Zero seed: replaced by SEED and flagged.
    b_sl = 1'b1; b_sv = 32'h0;
    @(posedge clk);
    #1 b_sl = 1'b0;
    check("zs_lerr", b_lerr, 1'b1);
    b_wait(n);
    check("zs_latency", n, 32);
    check("zs_data", b_data, w1);
    check("zs_lerr_sticky", b_lerr, 1'b1);

    // Reset mid-OFFER, then the identical start-up sequence.
    reset_pulse("rst_offer");
    b_first_word("rst_offer_w");

    // A non-zero seed clears lock_err.
    b_sl = 1'b1; b_sv = 32'h0;
    @(posedge clk);
    #1 b_sl = 1'b1;
    b_sv = 32'h5;
    check("lerr_set", b_lerr, 1'b1);
    @(posedge clk);
    #1 b_sl = 1'b0;
    check("lerr_clr", b_lerr, 1'b0);
    b_wait(n);
    check("seed5_data", b_data, adv(32'h5, 32));

    // Reset mid-FILL.
    b_req = 4'b1000;
    @(posedge clk);
    #1 b_req = '0;
    repeat (10) @(posedge clk);
    #1;
    reset_pulse("rst_fill");
    b_first_word("rst_fill_w");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
